// File: rtl/latch_capture_fifo.sv
// latch_capture_fifo
// Captures an asynchronous data bus D on each falling edge of an asynchronous
// latch enable LE. LE passes through a synchroniser and an edge detector. The
// D word is delayed by the same number of stages as LE, so each word lines up
// with its edge. Captured words are queued in a small FIFO for a consumer.
//
// Optional feature: define LATCH_CAPTURE_OVERRUN_COUNT_EN to add the 8-bit
// saturating overrun_cnt output, which counts dropped captures.

module latch_capture_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           D,
  input  logic                       LE,
  input  logic                       pop,
  output logic [WIDTH-1:0]           Q,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun
`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
  ,
  output logic [7:0]                 overrun_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [SYNC_STAGES-1:0] r_le_sync;
  logic                   r_le_hist;
  logic [WIDTH-1:0]       r_d_pipe [SYNC_STAGES+1];
  logic                   r_rst_d;
  logic                   r_push;

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_overrun;

  logic                   w_fall;
  logic                   w_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_drop;

  // A falling edge is seen when the history flop is still 1 and the last
  // synchroniser stage has already gone to 0.
  assign w_fall  = r_le_hist & ~r_le_sync[SYNC_STAGES-1];
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = pop & w_valid;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;

  // Synchronise LE, delay D to match it, and register the one-cycle push strobe.
  // NOTE: all state is updated with non-blocking assignments. Each flop in the
  // shift chains then samples its neighbour's value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_le_sync <= '0;
      r_le_hist <= 1'b0;
      r_rst_d   <= 1'b1;
      r_push    <= 1'b0;
      for (int i = 0; i <= SYNC_STAGES; i++) r_d_pipe[i] <= '0;
    end else begin
      r_le_sync   <= {r_le_sync[SYNC_STAGES-2:0], LE};
      r_le_hist   <= r_le_sync[SYNC_STAGES-1];
      r_rst_d     <= 1'b0;
      r_push      <= w_fall & ~r_rst_d;
      r_d_pipe[0] <= D;
      for (int i = 1; i <= SYNC_STAGES; i++) r_d_pipe[i] <= r_d_pipe[i-1];
    end
  end

  // Storage array: written at the tail on an accepted push.
  // NOTE: the array has no reset. Its contents are only visible through Q
  // when count is non-zero, and reset clears count.
  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wr_ptr] <= r_d_pipe[SYNC_STAGES];
  end

  // Pointers, occupancy count and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overrun <= 1'b1;
    end
  end

`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
  logic [7:0] r_overrun_cnt;

  // Saturating count of dropped captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun_cnt <= '0;
    end else if (w_drop && r_overrun_cnt != 8'hFF) begin
      r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign Q       = w_valid ? r_mem[r_rd_ptr] : '0;
  assign valid   = w_valid;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_latch_capture_fifo.sv
// Testbench for latch_capture_fifo.
// A queue-based reference model decides capture timing from the LE sample
// history. A capture lands SYNC+2 edges after the first low sample of a
// falling LE, and it carries the D value seen at that same edge.
// Directed scenarios run first, then randomized LE/D/pop/reset traffic.
// The model is checked against the DUT after every clock edge.

module tb_latch_capture_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] D;
  logic             LE;
  logic             pop;
  logic [WIDTH-1:0] Q;
  logic             valid;
  logic             full;
  logic [2:0]       count;
  logic             overrun;
`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
  logic [7:0]       overrun_cnt;
`endif

  latch_capture_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .D(D), .LE(LE), .pop(pop),
    .Q(Q), .valid(valid), .full(full), .count(count), .overrun(overrun)
`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_ovr;
  int               m_ovcnt;
  bit               lh [SYNC+2];   // lh[0] = LE sampled at the previous edge
  logic [WIDTH-1:0] dh [SYNC+2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Advance the model by one rising edge using the inputs presented at it.
  task automatic model_edge();
    bit               cap;
    bit               dp;
    logic [WIDTH-1:0] cd;
    if (reset) begin
      mq.delete();
      m_ovr   = 1'b0;
      m_ovcnt = 0;
      for (int i = 0; i < SYNC + 2; i++) begin
        lh[i] = 1'b0;
        dh[i] = '0;
      end
    end else begin
      cap = (lh[SYNC] == 1'b0) && (lh[SYNC+1] == 1'b1);
      cd  = dh[SYNC];
      dp  = pop && (mq.size() > 0);
      if (dp) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(cd);
        else begin
          m_ovr = 1'b1;
          if (m_ovcnt < 255) m_ovcnt++;
        end
      end
      for (int i = SYNC + 1; i > 0; i--) begin
        lh[i] = lh[i-1];
        dh[i] = dh[i-1];
      end
      lh[0] = LE;
      dh[0] = D;
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(mq.size()));
    check("valid", 32'(valid), 32'(mq.size() != 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("Q", 32'(Q), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovcnt));
`endif
  endtask

  // Present inputs for one clock period, then check after the rising edge.
  task automatic cycle(input bit le_i, input logic [WIDTH-1:0] d_i, input bit pop_i, input bit rst_i);
    LE    = le_i;
    D     = d_i;
    pop   = pop_i;
    reset = rst_i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // One LE high->low cycle. The word is stored at the edge of the last cycle,
  // which can optionally coincide with a pop.
  task automatic capture(input logic [WIDTH-1:0] d_i, input bit pop_last);
    repeat (2) cycle(1'b1, d_i, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, d_i, 1'b0, 1'b0);
    cycle(1'b0, d_i, pop_last, 1'b0);
  endtask

  initial begin
    bit               le_r;
    logic [WIDTH-1:0] exp_q [3];

    LE = 1'b0; D = '0; pop = 1'b0; reset = 1'b1;

    // Reset defaults
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);

    // Single capture of 0xA5: valid rises on the 4th edge after the first low sample
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'hA5, 1'b0, 1'b0);
    check("a5_not_early", 32'(valid), 32'd0);
    cycle(1'b0, 8'hA5, 1'b0, 1'b0);
    check("a5_valid", 32'(valid), 32'd1);
    check("a5_Q", 32'(Q), 32'hA5);
    check("a5_count", 32'(count), 32'd1);

    // Fill to full, then a fifth capture is dropped
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 1; v <= 4; v++) capture(8'(v), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    capture(8'h05, 1'b0);
    check("drop_overrun", 32'(overrun), 32'd1);
    check("drop_Q", 32'(Q), 32'h01);
    check("drop_count", 32'(count), 32'd4);

    // Full FIFO: capture 0x10 coinciding with a pop
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 1; v <= 4; v++) capture(8'(v), 1'b0);
    capture(8'h10, 1'b1);
    check("pp_count", 32'(count), 32'd4);
    check("pp_overrun", 32'(overrun), 32'd0);
    check("pp_Q0", 32'(Q), 32'h02);
    exp_q[0] = 8'h03; exp_q[1] = 8'h04; exp_q[2] = 8'h10;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("pp_Qn", 32'(Q), 32'(exp_q[i]));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_empty_valid", 32'(valid), 32'd0);

    // Pop on empty, then a capture of 0x3C
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("epop_count", 32'(count), 32'd0);
    check("epop_Q", 32'(Q), 32'd0);
    capture(8'h3C, 1'b0);
    check("epop_3c", 32'(Q), 32'h3C);
    check("epop_cnt1", 32'(count), 32'd1);

    // LE low through reset release: no capture
    repeat (3) cycle(1'b1, 8'h77, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 8'h77, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 8'h77, 1'b0, 1'b0);
    check("lerst_count", 32'(count), 32'd0);

    // Two entries stored, a capture in flight, then reset pulsed
    capture(8'h11, 1'b0);
    capture(8'h22, 1'b0);
    repeat (2) cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h33, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 8'h33, 1'b0, 1'b0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);

    // Randomized traffic
    le_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) le_r = ~le_r;
      cycle(le_r, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
    end

`ifdef LATCH_CAPTURE_OVERRUN_COUNT_EN
    // 300 drops into a full FIFO saturate the counter
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 0; v < 304; v++) capture(8'(v), 1'b0);
    check("ovcnt_sat", 32'(overrun_cnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
